// File: rtl/add_sub4_acc_ctrl_if.sv
// Command, adder and result signals for add_sub4_acc_ctrl.
// The slave modport is the controller's view; the master modport is the
// view of whatever drives commands, models ADD_SUB4 and observes results.
interface add_sub4_acc_ctrl_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [2:0] CMD_OP;
  logic [3:0] CMD_DATA;
  logic [3:0] ADDER_A;
  logic [3:0] ADDER_B;
  logic       ADDER_SUB;
  logic [3:0] ADDER_ANS;
  logic       ADDER_OVF;
  logic [3:0] ACC;
  logic       OVF_LAST;
  logic       OVF_STICKY;
  logic       RES_VALID;
  logic       BUSY;

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DATA, ADDER_ANS, ADDER_OVF,
    output CMD_READY, ADDER_A, ADDER_B, ADDER_SUB,
           ACC, OVF_LAST, OVF_STICKY, RES_VALID, BUSY
  );

  modport master (
    output CMD_VALID, CMD_OP, CMD_DATA, ADDER_ANS, ADDER_OVF,
    input  CMD_READY, ADDER_A, ADDER_B, ADDER_SUB,
           ACC, OVF_LAST, OVF_STICKY, RES_VALID, BUSY
  );
endinterface

// File: rtl/add_sub4_acc_ctrl.sv
// Command-driven 4-bit signed accumulator wrapped around an external
// ADD_SUB4. Operands/SUB are registered toward the adder; its result and
// overflow are captured into ACC and the overflow flags. MUL is performed
// as repeated addition through the same adder.
module add_sub4_acc_ctrl (
  input  logic CLK,
  input  logic RST,
  add_sub4_acc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_CLRF = 3'b101,
    OP_NEG  = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [3:0] opb_q, opb_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] acc_q, acc_d;
  logic       ovf_last_q, ovf_last_d;
  logic       ovf_sticky_q, ovf_sticky_d;
  logic       mul_ovf_q, mul_ovf_d;
  logic [3:0] adder_a_q, adder_a_d;
  logic [3:0] adder_b_q, adder_b_d;
  logic       adder_sub_q, adder_sub_d;

  logic       cmd_ready;
  logic       res_valid;
  logic       busy;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: accumulator, flags, latched command and adder inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q         <= OP_NOP;
      opb_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      ovf_last_q   <= 1'b0;
      ovf_sticky_q <= 1'b0;
      mul_ovf_q    <= 1'b0;
      adder_a_q    <= '0;
      adder_b_q    <= '0;
      adder_sub_q  <= 1'b0;
    end else begin
      op_q         <= op_d;
      opb_q        <= opb_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      ovf_last_q   <= ovf_last_d;
      ovf_sticky_q <= ovf_sticky_d;
      mul_ovf_q    <= mul_ovf_d;
      adder_a_q    <= adder_a_d;
      adder_b_q    <= adder_b_d;
      adder_sub_q  <= adder_sub_d;
    end
  end

  // Next-state, datapath updates and handshake/status outputs
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    opb_d        = opb_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    ovf_last_d   = ovf_last_q;
    ovf_sticky_d = ovf_sticky_q;
    mul_ovf_d    = mul_ovf_q;
    adder_a_d    = adder_a_q;
    adder_b_d    = adder_b_q;
    adder_sub_d  = adder_sub_q;
    cmd_ready    = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.CMD_VALID) begin
          state_d     = S_EXEC;
          op_d        = op_t'(bus.CMD_OP);
          mul_ovf_d   = 1'b0;
          adder_a_d   = '0;
          adder_b_d   = '0;
          adder_sub_d = 1'b0;
          case (op_t'(bus.CMD_OP))
            OP_LOAD: opb_d = bus.CMD_DATA;
            OP_ADD: begin
              opb_d     = bus.CMD_DATA;
              adder_a_d = acc_q;
              adder_b_d = bus.CMD_DATA;
            end
            OP_SUB: begin
              opb_d       = bus.CMD_DATA;
              adder_a_d   = acc_q;
              adder_b_d   = bus.CMD_DATA;
              adder_sub_d = 1'b1;
            end
            OP_NEG: begin
              opb_d       = acc_q;
              adder_b_d   = acc_q;
              adder_sub_d = 1'b1;
            end
            OP_MUL: begin
              // ACC is cleared at accept, so the first adder A operand is 0
              opb_d     = acc_q;
              cnt_d     = bus.CMD_DATA;
              acc_d     = '0;
              adder_b_d = acc_q;
            end
            default: ;
          endcase
        end
      end

      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_DONE;
        case (op_q)
          OP_ADD, OP_SUB, OP_NEG: begin
            acc_d        = bus.ADDER_ANS;
            ovf_last_d   = bus.ADDER_OVF;
            ovf_sticky_d = ovf_sticky_q | bus.ADDER_OVF;
          end
          OP_LOAD: begin
            acc_d      = opb_q;
            ovf_last_d = 1'b0;
          end
          OP_CLRF: begin
            ovf_last_d   = 1'b0;
            ovf_sticky_d = 1'b0;
          end
          OP_MUL: begin
            if (cnt_q != 4'd0) begin
              // Feed each partial sum straight back as the next A operand
              state_d   = S_EXEC;
              acc_d     = bus.ADDER_ANS;
              cnt_d     = cnt_q - 4'd1;
              mul_ovf_d = mul_ovf_q | bus.ADDER_OVF;
              adder_a_d = bus.ADDER_ANS;
              adder_b_d = opb_q;
            end else begin
              ovf_last_d   = mul_ovf_q;
              ovf_sticky_d = ovf_sticky_q | mul_ovf_q;
            end
          end
          default: ;
        endcase
      end

      S_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.CMD_READY  = cmd_ready;
  assign bus.RES_VALID  = res_valid;
  assign bus.BUSY       = busy;
  assign bus.ACC        = acc_q;
  assign bus.OVF_LAST   = ovf_last_q;
  assign bus.OVF_STICKY = ovf_sticky_q;
  assign bus.ADDER_A    = adder_a_q;
  assign bus.ADDER_B    = adder_b_q;
  assign bus.ADDER_SUB  = adder_sub_q;

endmodule

// File: tb/tb_add_sub4_acc_ctrl.sv
// Testbench for add_sub4_acc_ctrl with an ADD_SUB4 behavioural model and
// an in-order result scoreboard fed from an integer-arithmetic model.
module tb_add_sub4_acc_ctrl;

  logic clk;
  logic rst;

  add_sub4_acc_ctrl_if ifc();

  add_sub4_acc_ctrl dut (
    .CLK (clk),
    .RST (rst),
    .bus (ifc.slave)
  );

  // ADD_SUB4: 4-bit two's complement add/subtract with signed overflow
  logic [3:0] addsub_ans;
  assign addsub_ans    = ifc.ADDER_SUB ? (ifc.ADDER_A - ifc.ADDER_B) : (ifc.ADDER_A + ifc.ADDER_B);
  assign ifc.ADDER_ANS = addsub_ans;
  assign ifc.ADDER_OVF = ifc.ADDER_SUB ?
                         ((ifc.ADDER_A[3] != ifc.ADDER_B[3]) && (addsub_ans[3] != ifc.ADDER_A[3])) :
                         ((ifc.ADDER_A[3] == ifc.ADDER_B[3]) && (addsub_ans[3] != ifc.ADDER_A[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] acc;
    logic       last;
    logic       sticky;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         n_accepts = 0;
  logic [3:0] m_acc;
  logic       m_last;
  logic       m_sticky;

  function automatic int wrap4(input int v);
    logic [3:0] w;
    w = v[3:0];
    return int'($signed(w));
  endfunction

  function automatic bit out_of_range(input int v);
    return (v > 7) || (v < -8);
  endfunction

  task automatic model_reset();
    m_acc    = '0;
    m_last   = 1'b0;
    m_sticky = 1'b0;
    sb.delete();
  endtask

  // Reference behaviour applied at accept; pushes the expected final result
  task automatic model_apply(input logic [2:0] op, input logic [3:0] d);
    int   sa;
    int   sd;
    int   r;
    int   t;
    int   n;
    bit   o;
    exp_t e;
    sa = $signed(m_acc);
    sd = $signed(d);
    n  = int'(d);
    case (op)
      3'b001: begin m_acc = d; m_last = 1'b0; end
      3'b010: begin r = sa + sd; o = out_of_range(r); m_acc = 4'(r); m_last = o; m_sticky |= o; end
      3'b011: begin r = sa - sd; o = out_of_range(r); m_acc = 4'(r); m_last = o; m_sticky |= o; end
      3'b100: begin
        r = 0;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
          t = r + sa;
          if (out_of_range(t)) o = 1'b1;
          r = wrap4(t);
        end
        m_acc = 4'(r);
        m_last = o;
        m_sticky |= o;
      end
      3'b101: begin m_last = 1'b0; m_sticky = 1'b0; end
      3'b110: begin r = 0 - sa; o = out_of_range(r); m_acc = 4'(r); m_last = o; m_sticky |= o; end
      default: ;
    endcase
    e.acc    = m_acc;
    e.last   = m_last;
    e.sticky = m_sticky;
    sb.push_back(e);
  endtask

  // Accept predictor and result monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ifc.CMD_VALID && ifc.CMD_READY) begin
        model_apply(ifc.CMD_OP, ifc.CMD_DATA);
        n_accepts++;
      end
      if (ifc.RES_VALID) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: RES_VALID with acc=%b but no result expected", ifc.ACC);
        end else begin
          e = sb.pop_front();
          if ({ifc.ACC, ifc.OVF_LAST, ifc.OVF_STICKY} !== e) begin
            errors++;
            $display("FAIL sb_result: got acc=%b last=%b sticky=%b expected acc=%b last=%b sticky=%b",
                     ifc.ACC, ifc.OVF_LAST, ifc.OVF_STICKY, e.acc, e.last, e.sticky);
          end
        end
      end
    end
  end

  // Issue one command and check its RES_VALID latency; entered/left at posedge+#1
  task automatic do_op(input logic [2:0] op, input logic [3:0] d, input int exp_lat, input string name);
    int n;
    n = 0;
    while (!ifc.CMD_READY && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s ready_timeout: CMD_READY=%b required 1", name, ifc.CMD_READY);
    end
    ifc.CMD_VALID = 1'b1;
    ifc.CMD_OP    = op;
    ifc.CMD_DATA  = d;
    @(posedge clk); #1;
    ifc.CMD_VALID = 1'b0;
    n = 1;
    @(negedge clk);
    while (!ifc.RES_VALID && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, n, exp_lat);
    end
    @(posedge clk); #1;
    checks++;
    if (ifc.CMD_READY !== 1'b1 || ifc.RES_VALID !== 1'b0 || ifc.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: ready=%b res_valid=%b busy=%b required 1 0 0",
               name, ifc.CMD_READY, ifc.RES_VALID, ifc.BUSY);
    end
  endtask

  task automatic check_result(input string name, input logic [3:0] acc, input logic last, input logic sticky);
    checks++;
    if (ifc.ACC !== acc || ifc.OVF_LAST !== last || ifc.OVF_STICKY !== sticky) begin
      errors++;
      $display("FAIL %s: got acc=%b last=%b sticky=%b required acc=%b last=%b sticky=%b",
               name, ifc.ACC, ifc.OVF_LAST, ifc.OVF_STICKY, acc, last, sticky);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.CMD_VALID = 1'b0;
    ifc.CMD_OP    = '0;
    ifc.CMD_DATA  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_result("reset_flags", 4'b0000, 1'b0, 1'b0);
    checks++;
    if ({ifc.RES_VALID, ifc.BUSY, ifc.CMD_READY, ifc.ADDER_A, ifc.ADDER_B, ifc.ADDER_SUB} !== {3'b001, 9'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got rv=%b busy=%b rdy=%b a=%b b=%b sub=%b required 0 0 1 0000 0000 0",
               ifc.RES_VALID, ifc.BUSY, ifc.CMD_READY, ifc.ADDER_A, ifc.ADDER_B, ifc.ADDER_SUB);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    do_op(3'b001, 4'd5, 2, "load5");
    do_op(3'b010, 4'd3, 2, "add3");
    check_result("add_overflow", 4'b1000, 1'b1, 1'b1);
  endtask

  task automatic test_sub();
    do_op(3'b101, 4'd0, 2, "clrf");
    do_op(3'b001, 4'd3, 2, "load3");
    do_op(3'b011, 4'd5, 2, "sub5");
    check_result("sub_negative", 4'b1110, 1'b0, 1'b0);
  endtask

  task automatic test_mul();
    do_op(3'b001, 4'd3, 2, "load3");
    do_op(3'b100, 4'd2, 4, "mul2");
    check_result("mul2", 4'd6, 1'b0, 1'b0);
    do_op(3'b001, 4'd3, 2, "load3");
    do_op(3'b100, 4'd3, 5, "mul3");
    check_result("mul3_wrap", 4'b1001, 1'b1, 1'b1);
    do_op(3'b100, 4'd0, 2, "mul0");
    check_result("mul0", 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_neg();
    do_op(3'b001, 4'b1000, 2, "load_min");
    do_op(3'b110, 4'd0, 2, "neg_min");
    check_result("neg_min", 4'b1000, 1'b1, 1'b1);
    do_op(3'b001, 4'b1101, 2, "load_m3");
    do_op(3'b110, 4'd0, 2, "neg_m3");
    check_result("neg_m3", 4'd3, 1'b0, 1'b1);
  endtask

  task automatic test_nop_reserved();
    do_op(3'b101, 4'd0, 2, "clrf");
    do_op(3'b001, 4'd2, 2, "load2");
    do_op(3'b010, 4'd7, 2, "add7");
    do_op(3'b000, 4'd5, 2, "nop");
    check_result("nop_hold", 4'b1001, 1'b1, 1'b1);
    do_op(3'b111, 4'd5, 2, "rsvd");
    check_result("rsvd_hold", 4'b1001, 1'b1, 1'b1);
    do_op(3'b101, 4'd0, 2, "clrf2");
    check_result("clrf_keeps_acc", 4'b1001, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int  acc0;
    bit  got;
    do_op(3'b001, 4'd1, 2, "load1");
    acc0 = n_accepts;
    ifc.CMD_VALID = 1'b1;
    ifc.CMD_OP    = 3'b100;
    ifc.CMD_DATA  = 4'd7;
    @(posedge clk); #1;
    ifc.CMD_OP   = 3'b010;
    ifc.CMD_DATA = 4'd1;
    for (int unsigned cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      checks++;
      if (ifc.CMD_READY !== (cyc == 10) || ifc.RES_VALID !== (cyc == 9)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: ready=%b res_valid=%b required %b %b",
                 cyc, ifc.CMD_READY, ifc.RES_VALID, (cyc == 10), (cyc == 9));
      end
      @(posedge clk); #1;
    end
    ifc.CMD_VALID = 1'b0;
    got = 1'b0;
    for (int unsigned i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ifc.RES_VALID) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_add_result: RES_VALID=0 required 1 within 10 cycles");
    end
    @(posedge clk); #1;
    check_result("b2b_final", 4'b1000, 1'b1, 1'b1);
    checks++;
    if (n_accepts - acc0 != 2) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d required 2", n_accepts - acc0);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    do_op(3'b001, 4'd7, 2, "load7");
    do_op(3'b010, 4'd1, 2, "add1");
    ifc.CMD_VALID = 1'b1;
    ifc.CMD_OP    = 3'b100;
    ifc.CMD_DATA  = 4'd7;
    @(posedge clk); #1;
    ifc.CMD_VALID = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_result("rst_mid_mul", 4'd0, 1'b0, 1'b0);
    checks++;
    if (ifc.CMD_READY !== 1'b1 || ifc.BUSY !== 1'b0 || ifc.RES_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_mul_ctrl: ready=%b busy=%b rv=%b required 1 0 0",
               ifc.CMD_READY, ifc.BUSY, ifc.RES_VALID);
    end
    seen = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ifc.RES_VALID) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_no_pulse: RES_VALID seen=1 required 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [3:0] d;
    for (int unsigned i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = 4'($urandom_range(0, 15));
      do_op(op, d, (op == 3'b100) ? int'(d) + 2 : 2, "random");
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results outstanding required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_mul();
    test_neg();
    test_nop_reserved();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
